i2c_cmd_arbiter: RTL and testbench

Round-robin controller that shares one I2C master engine between `N_REQ` independent requesters. It latches one requester's transaction (address, direction, speed, write byte) and drives the master's 32-bit command word with a start handshake. It then waits for the master's ready flag, returns the read byte, and frees the bus. A watchdog aborts hung transfers by pulsing the master's reset bit.

---
 rtl/i2c_pkg.sv | 47 ++++
 rtl/i2c_cmd_arbiter_rr.sv | 34 +++
 rtl/i2c_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master and its command arbiter.
//   - command word bit positions (master command/status interface)
//   - speed encodings
//   - arbiter FSM state enum and latched-transaction struct
//   - build_cmd: packs a transaction into the 32-bit command word
package i2c_pkg;

  localparam int unsigned START    = 0;
  localparam int unsigned RESET    = 1;
  localparam int unsigned SPEED    = 2;
  localparam int unsigned RW       = 3;
  localparam int unsigned ADDR_LSB = 4;
  localparam int unsigned DATA_LSB = 11;
  localparam int unsigned READY    = 8;

  localparam logic SPEED_100K = 1'b0;
  localparam logic SPEED_400K = 1'b1;

  localparam logic [31:0] CMD_ABORT = 32'(1) << RESET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_DONE,
    ST_ABORT
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic       speed;
  } txn_t;

  function automatic logic [31:0] build_cmd(input logic start, input txn_t t);
    logic [31:0] c;
    c                  = '0;
    c[START]           = start;
    c[SPEED]           = t.speed;
    c[RW]              = t.rw;
    c[ADDR_LSB +: 7]   = t.addr;
    c[DATA_LSB +: 8]   = t.wdata;
    return c;
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req    : request vector
//   rr_ptr : index with highest priority this round
//   gnt    : one-hot grant (zero when no request)
//   idx    : index of the granted requester (zero when no request)
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] pos;

  // Scan offsets from farthest to nearest so the closest set bit at or
  // after rr_ptr is the last assignment and therefore wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    for (int unsigned k = N; k > 0; k--) begin
      pos = W'((32'(rr_ptr) + k - 1) % 32'(N));
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C master engine between N_REQ requesters.
//   clk, rst            : clock, asynchronous active-high reset
//   req/req_rw/req_speed: per-requester request level, direction, speed
//   req_addr/req_wdata  : packed per-requester 7-bit address / 8-bit data
//   gnt                 : one-hot ownership of the master
//   done/err            : one-cycle completion / timeout-abort pulses
//   rdata               : last read byte, held until next completion
//   i2c_cmd/i2c_status  : command word to, and status word from, the master
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [N_REQ-1:0]     req_speed,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic [7:0]           rdata,
  output logic [31:0]          i2c_cmd,
  input  logic [31:0]          i2c_status
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n, cur, cur_n, pick_idx, ptr_adv;
  logic [N_REQ-1:0] pick_gnt, gnt_n, done_n, err_n;
  txn_t             txn, txn_n;
  logic [15:0]      wdog, wdog_n;
  logic [7:0]       rdata_n;
  logic [31:0]      cmd_n;
  logic             timeout, ready;
  logic [6:0]       addr_a  [N_REQ];
  logic [7:0]       wdata_a [N_REQ];
  logic             unused_status;

  assign unused_status = ^i2c_status[31:9];
  assign ready         = i2c_status[READY];
  assign timeout       = (wdog == 16'(TIMEOUT - 1));
  assign ptr_adv       = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + 1'b1;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_a[i]  = req_addr[i*7 +: 7];
      wdata_a[i] = req_wdata[i*8 +: 8];
    end
  end

  rr_arbiter #(.N(N_REQ), .W(IDX_W)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    cur_n    = cur;
    txn_n    = txn;
    gnt_n    = gnt;
    done_n   = '0;
    err_n    = '0;
    rdata_n  = rdata;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n     = ST_LAUNCH;
          cur_n       = pick_idx;
          gnt_n       = pick_gnt;
          txn_n.addr  = addr_a[pick_idx];
          txn_n.wdata = wdata_a[pick_idx];
          txn_n.rw    = req_rw[pick_idx];
          txn_n.speed = req_speed[pick_idx] ? SPEED_400K : SPEED_100K;
        end
      end
      ST_LAUNCH, ST_BUSY: begin
        if (timeout) begin
          state_n    = ST_ABORT;
          gnt_n      = '0;
          err_n[cur] = 1'b1;
        end else if (state == ST_LAUNCH) begin
          if (!ready) state_n = ST_BUSY;
        end else if (ready) begin
          // done, gnt drop and rdata capture all land on the same edge so
          // rdata is already valid in the done cycle.
          state_n     = ST_DONE;
          gnt_n       = '0;
          done_n[cur] = 1'b1;
          if (txn.rw) rdata_n = i2c_status[7:0];
        end
      end
      ST_DONE: begin
        state_n  = ST_IDLE;
        rr_ptr_n = ptr_adv;
      end
      ST_ABORT: begin
        if (wdog == 16'd1) begin
          state_n  = ST_IDLE;
          rr_ptr_n = ptr_adv;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state || state_n == ST_IDLE) wdog_n = '0;
    else                                        wdog_n = wdog + 16'd1;

    unique case (state_n)
      ST_LAUNCH: cmd_n = build_cmd(1'b1, txn_n);
      ST_BUSY:   cmd_n = build_cmd(1'b0, txn_n);
      ST_ABORT:  cmd_n = CMD_ABORT;
      default:   cmd_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      cur     <= '0;
      txn     <= '0;
      wdog    <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      rdata   <= '0;
      i2c_cmd <= '0;
    end else begin
      state   <= state_n;
      rr_ptr  <= rr_ptr_n;
      cur     <= cur_n;
      txn     <= txn_n;
      wdog    <= wdog_n;
      gnt     <= gnt_n;
      done    <= done_n;
      err     <= err_n;
      rdata   <= rdata_n;
      i2c_cmd <= cmd_n;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter with a behavioural I2C master model.
module tb_i2c_cmd_arbiter;

  localparam int TO          = 250;
  localparam int READY_DELAY = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_rw, req_speed;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, done, err;
  logic [7:0]  rdata;
  logic [31:0] i2c_cmd;
  logic [31:0] i2c_status = 32'h100;

  i2c_cmd_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rw     (req_rw),
    .req_speed  (req_speed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .i2c_cmd    (i2c_cmd),
    .i2c_status (i2c_status)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- master model ----------------
  bit         hang = 0;
  logic [7:0] rd_byte = 8'h00;
  bit         mbusy = 0;
  int         mcnt = 0;

  always @(posedge clk) begin
    if (rst || i2c_cmd[1]) begin
      i2c_status <= 32'h100;
      mbusy      <= 0;
      mcnt       <= 0;
    end else if (!mbusy) begin
      if (i2c_cmd[0]) begin
        i2c_status[8] <= 1'b0;
        mbusy         <= 1;
        mcnt          <= 0;
      end
    end else if (!hang && mcnt == READY_DELAY - 1) begin
      i2c_status <= {23'b0, 1'b1, rd_byte};
      mbusy      <= 0;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]  g;
    logic [31:0] lc;
    logic [31:0] bc;
  } gexp_t;

  typedef struct {
    bit         is_err;
    logic [3:0] idx;
    logic [7:0] rd;
    int         busy;
  } ev_t;

  gexp_t g_q[$];
  ev_t   ev_q[$];

  function automatic logic [31:0] mk(input logic st, input logic [6:0] a, input logic rw,
                                     input logic sp, input logic [7:0] wd);
    return {13'b0, wd, a, rw, sp, 1'b0, st};
  endfunction

  task automatic push_g(input int i, input logic [31:0] lc, input logic [31:0] bc);
    gexp_t e;
    e.g = 4'(1 << i); e.lc = lc; e.bc = bc;
    g_q.push_back(e);
  endtask

  task automatic push_ev(input bit is_err, input int i, input logic [7:0] rd, input int busy);
    ev_t e;
    e.is_err = is_err; e.idx = 4'(1 << i); e.rd = rd; e.busy = busy;
    ev_q.push_back(e);
  endtask

  logic [3:0]  prev_gnt = '0;
  logic [31:0] cur_busy = '0;
  bit          busy_chk = 0;
  int          busy_cnt = 0;
  int          abort_ph = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
      abort_ph = 0;
    end else begin
      gexp_t ge;
      ev_t   ev;
      if (!$onehot0(gnt)) check("gnt_onehot", 32'(gnt), 32'(0));
      if (gnt != 0 && prev_gnt == 0) begin
        if (g_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'(0));
        else begin
          ge = g_q.pop_front();
          check("gnt", 32'(gnt), 32'(ge.g));
          check("launch_cmd", i2c_cmd, ge.lc);
          cur_busy = ge.bc;
          busy_chk = 0;
          busy_cnt = 0;
        end
      end
      if (gnt != 0 && !i2c_cmd[0] && !i2c_cmd[1]) begin
        busy_cnt++;
        if (!busy_chk) begin
          check("busy_cmd", i2c_cmd, cur_busy);
          busy_chk = 1;
        end
      end
      if (abort_ph == 1) begin
        check("abort_cmd_2nd", i2c_cmd, 32'h2);
        abort_ph = 2;
      end else if (abort_ph == 2) begin
        check("abort_cmd_clear", i2c_cmd, 32'h0);
        abort_ph = 0;
      end
      if (done != 0 || err != 0) begin
        if (ev_q.size() == 0) check("unexpected_done_err", {24'b0, done, err}, 32'h0);
        else begin
          ev = ev_q.pop_front();
          if (ev.is_err) begin
            check("err", 32'(err), 32'(ev.idx));
            check("err_no_done", 32'(done), 32'(0));
            check("abort_cmd_1st", i2c_cmd, 32'h2);
            check("timeout_busy_cycles", 32'(busy_cnt), 32'(ev.busy));
            check("err_gnt_clear", 32'(gnt), 32'(0));
            abort_ph = 1;
          end else begin
            check("done", 32'(done), 32'(ev.idx));
            check("done_no_err", 32'(err), 32'(0));
            check("done_gnt_clear", 32'(gnt), 32'(0));
            check("rdata", 32'(rdata), 32'(ev.rd));
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_fields(input int i, input logic [6:0] a, input logic rw,
                            input logic sp, input logic [7:0] wd);
    req_addr[i*7 +: 7]  = a;
    req_wdata[i*8 +: 8] = wd;
    req_rw[i]           = rw;
    req_speed[i]        = sp;
  endtask

  task automatic wait_grant(input logic [3:0] g);
    int n = 0;
    while (gnt != g && n < 3000) begin @(negedge clk); n++; end
    if (gnt != g) check("wait_grant_timeout", 32'(gnt), 32'(g));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!(gnt != 0 && !i2c_cmd[0]) && n < 100) begin @(negedge clk); n++; end
    if (!(gnt != 0 && !i2c_cmd[0])) check("wait_busy_timeout", i2c_cmd, 32'h0);
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    while (done == 0 && err == 0 && n < 2000) begin @(negedge clk); n++; end
    if (done == 0 && err == 0) check("wait_end_timeout", 32'(done | err), 32'h1);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; req_rw = '0; req_speed = '0; req_addr = '0; req_wdata = '0;
    set_fields(0, 7'h50, 1'b0, 1'b0, 8'hA5);
    set_fields(1, 7'h21, 1'b0, 1'b1, 8'h5A);
    set_fields(2, 7'h1D, 1'b1, 1'b1, 8'h00);
    set_fields(3, 7'h7F, 1'b0, 1'b0, 8'hFF);
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_cmd", i2c_cmd, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // contention: all four held, ptr starts at 0
    rd_byte = 8'h96;
    push_g(0, 32'h52D01, 32'h52D00);                     push_ev(0, 0, 8'h00, 0);
    push_g(1, mk(1, 7'h21, 0, 1, 8'h5A), mk(0, 7'h21, 0, 1, 8'h5A)); push_ev(0, 1, 8'h00, 0);
    push_g(2, 32'h1DD, 32'h1DC);                         push_ev(0, 2, 8'h96, 0);
    push_g(3, mk(1, 7'h7F, 0, 0, 8'hFF), mk(0, 7'h7F, 0, 0, 8'hFF)); push_ev(0, 3, 8'h96, 0);
    push_g(0, 32'h52D01, 32'h52D00);                     push_ev(0, 0, 8'h96, 0);
    req = 4'b1111;
    wait_grant(4'b0001); wait_grant(4'b0010); wait_grant(4'b0100); wait_grant(4'b1000);
    wait_grant(4'b0001);
    req = '0;
    wait_end();
    repeat (3) @(negedge clk);

    // single write from requester 0
    push_g(0, 32'h52D01, 32'h52D00); push_ev(0, 0, 8'h96, 0);
    req[0] = 1'b1;
    wait_grant(4'b0001); wait_end(); req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // single read from requester 2
    rd_byte = 8'h3C;
    push_g(2, 32'h1DD, 32'h1DC); push_ev(0, 2, 8'h3C, 0);
    req[2] = 1'b1;
    wait_grant(4'b0100); wait_end(); req[2] = 1'b0;
    repeat (3) @(negedge clk);

    // request dropped mid-transfer still completes
    push_g(1, mk(1, 7'h21, 0, 1, 8'h5A), mk(0, 7'h21, 0, 1, 8'h5A)); push_ev(0, 1, 8'h3C, 0);
    req[1] = 1'b1;
    wait_grant(4'b0010); wait_busy();
    repeat (5) @(negedge clk);
    req[1] = 1'b0;
    wait_end();
    repeat (3) @(negedge clk);

    // timeout abort on requester 3
    hang = 1;
    push_g(3, mk(1, 7'h7F, 0, 0, 8'hFF), mk(0, 7'h7F, 0, 0, 8'hFF)); push_ev(1, 3, 8'h3C, TO);
    req[3] = 1'b1;
    wait_grant(4'b1000); wait_end(); req[3] = 1'b0;
    hang = 0;
    repeat (5) @(negedge clk);

    // requester 0 once more, leaves rr_ptr at 1
    push_g(0, 32'h52D01, 32'h52D00); push_ev(0, 0, 8'h3C, 0);
    req[0] = 1'b1;
    wait_grant(4'b0001); wait_end(); req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-BUSY: requester 1 owns, 0 and 3 pending
    push_g(1, mk(1, 7'h21, 0, 1, 8'h5A), mk(0, 7'h21, 0, 1, 8'h5A));
    req = 4'b1011;
    wait_grant(4'b0010); wait_busy();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    req[1] = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'(0));
    check("arst_cmd", i2c_cmd, 32'h0);
    check("arst_done", 32'(done), 32'(0));
    check("arst_err", 32'(err), 32'(0));
    check("arst_rdata", 32'(rdata), 32'(0));
    @(negedge clk); @(negedge clk);
    push_g(0, 32'h52D01, 32'h52D00); push_ev(0, 0, 8'h00, 0);
    push_g(3, mk(1, 7'h7F, 0, 0, 8'hFF), mk(0, 7'h7F, 0, 0, 8'hFF)); push_ev(0, 3, 8'h00, 0);
    rst = 1'b0;
    wait_grant(4'b0001); wait_end(); req[0] = 1'b0;
    wait_grant(4'b1000); wait_end(); req[3] = 1'b0;

    repeat (10) @(negedge clk);
    check("grant_queue_empty", 32'(g_q.size()), 32'(0));
    check("event_queue_empty", 32'(ev_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
